// File: rtl/vcpu32_pkg.sv
// Shared vcpu32 definitions: word/register-file sizes, their types, the write-port stage record,
// and a helper that measures a requester's distance along the round-robin scan.
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

package vcpu32_pkg;

    localparam int WORD_LENGTH = `WORD_LENGTH;
    localparam int RF_SIZE     = 16;
    localparam int RF_ADDR_W   = $clog2(RF_SIZE);

    typedef logic [RF_ADDR_W-1:0]   rf_addr_t;
    typedef logic [WORD_LENGTH-1:0] rf_word_t;

    typedef struct packed {
        logic     en;
        rf_addr_t addr;
        rf_word_t data;
    } rf_wr_t;

    // Position of idx in the scan that starts at ptr (0 = scanned first).
    function automatic int scan_dist(int idx, int ptr, int n);
        return (idx - ptr + n) % n;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Find-first-set over an N-bit mask, scanning start, start+1, ... modulo N.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     mask,
    input  logic [PTR_W-1:0] start,
    output logic             found,
    output logic [PTR_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    always_comb begin
        int j;
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(start) + k) % N;
            if (!found && mask[j]) begin
                found  = 1'b1;
                idx    = PTR_W'(j);
                onehot = N'(1) << j;
            end
        end
    end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Round-robin arbiter sharing the two register-file write ports among NUM_REQ writers.
// Define REGFILE_ARB_AGE_EN to force long-stalled requesters onto port 0.
module regfile_wport_arbiter
    import vcpu32_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int SIZE      = RF_SIZE,
    parameter int WIDTH     = `WORD_LENGTH,
    parameter int ADDR_W    = $clog2(SIZE),
    parameter int AGE_LIMIT = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      wp0_en,
    output logic [ADDR_W-1:0]         wp0_addr,
    output logic [WIDTH-1:0]          wp0_data,
    output logic                      wp1_en,
    output logic [ADDR_W-1:0]         wp1_addr,
    output logic [WIDTH-1:0]          wp1_data,
    output logic [SIZE-1:0]           wr_pend
);

    localparam int PTR_W = $clog2(NUM_REQ);

    genvar gi;

    logic [ADDR_W-1:0]  addr_s [NUM_REQ];
    logic [WIDTH-1:0]   data_s [NUM_REQ];
    logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next, last_idx;
    logic               found0_rr, found0, found1;
    logic [PTR_W-1:0]   idx0_rr, idx0, idx1;
    logic [NUM_REQ-1:0] oh0_rr, oh0, oh1, same_addr, mask1;
    rf_wr_t             wp0_reg, wp1_reg;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign addr_s[gi]    = req_addr[gi*ADDR_W +: ADDR_W];
            assign data_s[gi]    = req_data[gi*WIDTH +: WIDTH];
            assign same_addr[gi] = (addr_s[gi] == addr_s[idx0]);
        end
    endgenerate

    rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick0 (
        .mask   (req_valid),
        .start  (rr_ptr_reg),
        .found  (found0_rr),
        .idx    (idx0_rr),
        .onehot (oh0_rr)
    );

`ifdef REGFILE_ARB_AGE_EN
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);

    logic [AGE_W-1:0]   age_reg [NUM_REQ];
    logic [NUM_REQ-1:0] aged;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_aged
            assign aged[gi] = req_valid[gi] && (age_reg[gi] == AGE_W'(AGE_LIMIT));
        end
    endgenerate

    // Descending scan so the lowest-index aged requester takes port 0.
    always_comb begin
        found0 = found0_rr;
        idx0   = idx0_rr;
        oh0    = oh0_rr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (aged[k]) begin
                found0 = 1'b1;
                idx0   = PTR_W'(k);
                oh0    = NUM_REQ'(1) << k;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) age_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || req_ready[i])
                    age_reg[i] <= '0;
                else if (age_reg[i] != AGE_W'(AGE_LIMIT))
                    age_reg[i] <= age_reg[i] + 1'b1;
            end
        end
    end
`else
    assign found0 = found0_rr;
    assign idx0   = idx0_rr;
    assign oh0    = oh0_rr;
`endif

    // Port 1 never shares an address with port 0; same-address requesters wait a cycle.
    assign mask1 = req_valid & ~oh0 & ~same_addr;

    rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick1 (
        .mask   (mask1),
        .start  (rr_ptr_reg),
        .found  (found1),
        .idx    (idx1),
        .onehot (oh1)
    );

    assign req_ready = oh0 | oh1;

    always_comb begin
        last_idx    = idx0;
        rr_ptr_next = rr_ptr_reg;
        if (found1 && scan_dist(int'(idx1), int'(rr_ptr_reg), NUM_REQ) >
                      scan_dist(int'(idx0), int'(rr_ptr_reg), NUM_REQ))
            last_idx = idx1;
        if (found0)
            rr_ptr_next = PTR_W'((int'(last_idx) + 1) % NUM_REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= '0;
            wp0_reg    <= '0;
            wp1_reg    <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            if (found0)
                wp0_reg <= '{en: 1'b1, addr: rf_addr_t'(addr_s[idx0]), data: rf_word_t'(data_s[idx0])};
            else
                wp0_reg <= '0;
            if (found1)
                wp1_reg <= '{en: 1'b1, addr: rf_addr_t'(addr_s[idx1]), data: rf_word_t'(data_s[idx1])};
            else
                wp1_reg <= '0;
        end
    end

    assign wp0_en   = wp0_reg.en;
    assign wp0_addr = ADDR_W'(wp0_reg.addr);
    assign wp0_data = WIDTH'(wp0_reg.data);
    assign wp1_en   = wp1_reg.en;
    assign wp1_addr = ADDR_W'(wp1_reg.addr);
    assign wp1_data = WIDTH'(wp1_reg.data);

    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_pend
            assign wr_pend[gi] = (wp0_en && (wp0_addr == ADDR_W'(gi))) ||
                                 (wp1_en && (wp1_addr == ADDR_W'(gi)));
        end
    endgenerate

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Self-checking bench for regfile_wport_arbiter: directed scenarios plus randomized traffic
// against a scan-order reference model (aging model enabled with REGFILE_ARB_AGE_EN).
module tb_regfile_wport_arbiter;

    localparam int AGE_LIMIT = 7;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   valid = 4'b0;
    logic [3:0]   a_addr [4];
    logic [31:0]  a_data [4];
    logic [15:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         wp0_en, wp1_en;
    logic [3:0]   wp0_addr, wp1_addr;
    logic [31:0]  wp0_data, wp1_data;
    logic [15:0]  wr_pend;

    assign req_addr = {a_addr[3], a_addr[2], a_addr[1], a_addr[0]};
    assign req_data = {a_data[3], a_data[2], a_data[1], a_data[0]};

    regfile_wport_arbiter #(
        .NUM_REQ(4), .SIZE(16), .WIDTH(32), .AGE_LIMIT(AGE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .wp0_en(wp0_en), .wp0_addr(wp0_addr), .wp0_data(wp0_data),
        .wp1_en(wp1_en), .wp1_addr(wp1_addr), .wp1_data(wp1_data),
        .wr_pend(wr_pend)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_ptr;
    int          m_age [4];
    int          g0, g1;
    int          grant_cnt [4];
    logic [3:0]  exp_ready;
    logic        e_en0, e_en1;
    logic [3:0]  e_a0, e_a1;
    logic [31:0] e_d0, e_d1;

    function automatic void model_reset();
        m_ptr = 0;
        for (int i = 0; i < 4; i++) begin
            m_age[i] = 0;
            grant_cnt[i] = 0;
        end
        e_en0 = 0; e_a0 = 0; e_d0 = 0;
        e_en1 = 0; e_a1 = 0; e_d1 = 0;
    endfunction

    // Grants for the current inputs: first valid in scan order (or an aged requester) on
    // port 0, next valid in scan order with a different address on port 1.
    function automatic void model_eval();
        int i;
        g0 = -1;
        g1 = -1;
`ifdef REGFILE_ARB_AGE_EN
        for (int r = 0; r < 4; r++)
            if (g0 < 0 && valid[r] && m_age[r] == AGE_LIMIT) g0 = r;
`endif
        for (int k = 0; k < 4; k++) begin
            i = (m_ptr + k) % 4;
            if (g0 < 0 && valid[i]) g0 = i;
        end
        if (g0 >= 0) begin
            for (int k = 0; k < 4; k++) begin
                i = (m_ptr + k) % 4;
                if (g1 < 0 && i != g0 && valid[i] && a_addr[i] != a_addr[g0]) g1 = i;
            end
        end
        exp_ready = 4'b0;
        if (g0 >= 0) exp_ready[g0] = 1'b1;
        if (g1 >= 0) exp_ready[g1] = 1'b1;
    endfunction

    function automatic void model_commit();
        int last;
        e_en0 = (g0 >= 0); e_a0 = e_en0 ? a_addr[g0] : 4'd0; e_d0 = e_en0 ? a_data[g0] : 32'd0;
        e_en1 = (g1 >= 0); e_a1 = e_en1 ? a_addr[g1] : 4'd0; e_d1 = e_en1 ? a_data[g1] : 32'd0;
        for (int r = 0; r < 4; r++) begin
            if (!valid[r] || exp_ready[r]) m_age[r] = 0;
            else if (m_age[r] < AGE_LIMIT) m_age[r] = m_age[r] + 1;
            if (exp_ready[r]) grant_cnt[r] = grant_cnt[r] + 1;
        end
        if (g0 >= 0) begin
            last = g0;
            if (g1 >= 0 && ((g1 - m_ptr + 4) % 4) > ((g0 - m_ptr + 4) % 4)) last = g1;
            m_ptr = (last + 1) % 4;
        end
    endfunction

    function automatic logic [73:0] exp_stage();
        return {e_en0, e_a0, e_d0, e_en1, e_a1, e_d1};
    endfunction

    function automatic logic [73:0] act_stage();
        return {wp0_en, wp0_en ? wp0_addr : 4'd0, wp0_en ? wp0_data : 32'd0,
                wp1_en, wp1_en ? wp1_addr : 4'd0, wp1_en ? wp1_data : 32'd0};
    endfunction

    function automatic logic [15:0] exp_pend();
        logic [15:0] p;
        p = 16'h0;
        if (e_en0) p[e_a0] = 1'b1;
        if (e_en1) p[e_a1] = 1'b1;
        return p;
    endfunction

    task automatic apply_reset();
        rst   = 1'b1;
        valid = 4'b0;
        for (int i = 0; i < 4; i++) begin
            a_addr[i] = 4'd0;
            a_data[i] = 32'd0;
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_tests++;
        if ({wp0_en, wp1_en, wp0_addr, wp1_addr, wp0_data, wp1_data, wr_pend, req_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got en=%b%b addr=%h/%h data=%h/%h pend=%h ready=%b, expected all zero",
                     wp0_en, wp1_en, wp0_addr, wp1_addr, wp0_data, wp1_data, wr_pend, req_ready);
        end
        valid = 4'b0011; a_addr[0] = 4'd9; a_addr[1] = 4'd4;
        a_data[0] = $urandom; a_data[1] = $urandom;
        @(negedge clk);
        model_eval();
        @(posedge clk);
        model_commit();
        #1 valid = 4'b0;
        n_tests++;
        if ({wp0_en, wp1_en, wr_pend} !== {2'b11, 16'h0210}) begin
            n_fail++;
            $display("FAIL reset_inflight: got en=%b%b pend=%h expected en=11 pend=0210", wp0_en, wp1_en, wr_pend);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({wp0_en, wp1_en, wr_pend} !== 18'b0) begin
            n_fail++;
            $display("FAIL reset_async: got en=%b%b pend=%h expected 0/0/0000", wp0_en, wp1_en, wr_pend);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_two_grants();
        apply_reset();
        valid = 4'b0101;
        a_addr[0] = 4'd3; a_data[0] = 32'hAAAA_0000;
        a_addr[2] = 4'd5; a_data[2] = 32'h0000_5555;
        @(negedge clk);
        model_eval();
        n_tests++;
        if (req_ready !== 4'b0101) begin
            n_fail++;
            $display("FAIL two_ready: got %b expected 0101", req_ready);
        end
        @(posedge clk);
        model_commit();
        #1 valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            a_addr[i] = 4'(i + 10);
            a_data[i] = $urandom;
        end
        @(negedge clk);
        model_eval();
        n_tests++;
        if (act_stage() !== {1'b1, 4'd3, 32'hAAAA_0000, 1'b1, 4'd5, 32'h0000_5555} || wr_pend !== 16'h0028) begin
            n_fail++;
            $display("FAIL two_ports: got stage=%h pend=%h expected wp0=(1,3,aaaa0000) wp1=(1,5,5555) pend=0028",
                     act_stage(), wr_pend);
        end
        n_tests++;
        if (req_ready !== 4'b1001) begin
            n_fail++;
            $display("FAIL two_ptr: got ready %b expected 1001 (scan from 3)", req_ready);
        end
        @(posedge clk);
        model_commit();
        #1 valid = 4'b0;
        @(negedge clk);
        n_tests++;
        if (act_stage() !== exp_stage()) begin
            n_fail++;
            $display("FAIL two_drain: got %h expected %h", act_stage(), exp_stage());
        end
    endtask

    task automatic test_addr_conflict();
        apply_reset();
        valid = 4'b1011;
        a_addr[0] = 4'd7; a_data[0] = 32'h1111_0000;
        a_addr[1] = 4'd7; a_data[1] = 32'h2222_0001;
        a_addr[3] = 4'd2; a_data[3] = 32'h3333_0003;
        @(negedge clk);
        model_eval();
        n_tests++;
        if (req_ready !== 4'b1001) begin
            n_fail++;
            $display("FAIL conflict_ready: got %b expected 1001", req_ready);
        end
        @(posedge clk);
        model_commit();
        #1 valid = 4'b0010;
        @(negedge clk);
        model_eval();
        n_tests++;
        if (act_stage() !== {1'b1, 4'd7, 32'h1111_0000, 1'b1, 4'd2, 32'h3333_0003} || req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL conflict_first: got stage=%h ready=%b expected wp0=(1,7,11110000) wp1=(1,2,33330003) ready=0010",
                     act_stage(), req_ready);
        end
        @(posedge clk);
        model_commit();
        #1 valid = 4'b0;
        @(negedge clk);
        n_tests++;
        if (act_stage() !== {1'b1, 4'd7, 32'h2222_0001, 1'b0, 4'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL conflict_second: got %h expected wp0=(1,7,22220001) wp1 idle", act_stage());
        end
    endtask

    task automatic test_single();
        apply_reset();
        valid = 4'b1000;
        a_addr[3] = 4'd15; a_data[3] = 32'hCAFE_F00D;
        @(negedge clk);
        model_eval();
        n_tests++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL single_ready: got %b expected 1000", req_ready);
        end
        @(posedge clk);
        model_commit();
        #1 valid = 4'b1111;
        for (int i = 0; i < 4; i++) a_addr[i] = 4'(i);
        @(negedge clk);
        model_eval();
        n_tests++;
        if (act_stage() !== {1'b1, 4'd15, 32'hCAFE_F00D, 1'b0, 4'd0, 32'd0} || wr_pend !== 16'h8000) begin
            n_fail++;
            $display("FAIL single_port0: got stage=%h pend=%h expected wp0=(1,f,cafef00d) wp1 idle pend=8000",
                     act_stage(), wr_pend);
        end
        n_tests++;
        if (req_ready !== 4'b0011) begin
            n_fail++;
            $display("FAIL single_ptr: got ready %b expected 0011 (scan from 0)", req_ready);
        end
        @(posedge clk);
        model_commit();
        #1 valid = 4'b0;
    endtask

    task automatic test_fairness();
        apply_reset();
        valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            a_addr[i] = 4'(2 * i + 1);
            a_data[i] = $urandom;
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            model_eval();
            n_tests++;
            if (req_ready !== ((c % 2 == 0) ? 4'b0011 : 4'b1100) || act_stage() !== exp_stage()) begin
                n_fail++;
                $display("FAIL fair_cycle%0d: got ready=%b stage=%h expected ready=%b stage=%h",
                         c, req_ready, act_stage(), (c % 2 == 0) ? 4'b0011 : 4'b1100, exp_stage());
            end
            @(posedge clk);
            model_commit();
            #1;
            for (int i = 0; i < 4; i++) if (exp_ready[i]) a_data[i] = $urandom;
        end
        valid = 4'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (grant_cnt[i] != 4) begin
                n_fail++;
                $display("FAIL fair_count req%0d: got %0d grants expected 4", i, grant_cnt[i]);
            end
        end
    endtask

    task automatic test_aging();
        logic [3:0] want;
        apply_reset();
        valid = 4'b1011;
        a_addr[0] = 4'd6; a_addr[1] = 4'd6; a_addr[3] = 4'd9;
        for (int i = 0; i < 4; i++) a_data[i] = $urandom;
`ifdef REGFILE_ARB_AGE_EN
        want = 4'b1010;
`else
        want = 4'b1001;
`endif
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            model_eval();
            n_tests++;
            if (req_ready !== exp_ready || act_stage() !== exp_stage()) begin
                n_fail++;
                $display("FAIL aging_cycle%0d: got ready=%b stage=%h expected ready=%b stage=%h",
                         c, req_ready, act_stage(), exp_ready, exp_stage());
            end
            if (c == 7) begin
                n_tests++;
                if (req_ready !== want) begin
                    n_fail++;
                    $display("FAIL aging_8th: got ready %b expected %b", req_ready, want);
                end
            end
            @(posedge clk);
            model_commit();
            #1;
            if (exp_ready[0]) a_data[0] = $urandom;
            if (exp_ready[3]) a_data[3] = $urandom;
            if (exp_ready[1]) valid[1] = 1'b0;
        end
        valid = 4'b0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            model_eval();
            n_tests++;
            if (req_ready !== exp_ready || act_stage() !== exp_stage() || wr_pend !== exp_pend()) begin
                n_fail++;
                $display("FAIL rand_cycle%0d: got ready=%b stage=%h pend=%h expected ready=%b stage=%h pend=%h",
                         c, req_ready, act_stage(), wr_pend, exp_ready, exp_stage(), exp_pend());
            end
            if (wp0_en && wp1_en) begin
                n_tests++;
                if (wp0_addr === wp1_addr) begin
                    n_fail++;
                    $display("FAIL rand_distinct%0d: got both ports at addr %h expected distinct", c, wp0_addr);
                end
            end
            @(posedge clk);
            model_commit();
            #1;
            for (int i = 0; i < 4; i++) begin
                if (!valid[i] || exp_ready[i]) begin
                    valid[i]  = ($urandom_range(0, 3) != 0);
                    a_addr[i] = 4'($urandom_range(0, 5));
                    a_data[i] = $urandom;
                end
            end
        end
        valid = 4'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_two_grants();
        test_addr_conflict();
        test_single();
        test_fairness();
        test_aging();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
